// File: rtl/report_arbiter_pkg.sv
// Shared definitions for the report arbiter: source indices and FSM states.
package report_arbiter_pkg;

    localparam int unsigned NUM_SRC = 4;

    localparam logic [1:0] SRC_WATCH = 2'd0;
    localparam logic [1:0] SRC_SR04  = 2'd1;
    localparam logic [1:0] SRC_TEMP  = 2'd2;
    localparam logic [1:0] SRC_HUM   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_GAP
    } state_t;

endpackage

// File: rtl/report_arbiter_if.sv
// Request/grant bundle between control_unit, the arbiter and the report formatter.
interface report_arbiter_if;

    logic       iReqWatch;
    logic       iReqSr04;
    logic       iReqTemp;
    logic       iReqHum;
    logic       iRptDone;
    logic       oRptStart;
    logic [1:0] oRptSel;
    logic       oBusy;
    logic [3:0] oPending;
    logic       oOverrun;
    logic       oTimeout;

    modport master (
        output iReqWatch, iReqSr04, iReqTemp, iReqHum, iRptDone,
        input  oRptStart, oRptSel, oBusy, oPending, oOverrun, oTimeout
    );

    modport slave (
        input  iReqWatch, iReqSr04, iReqTemp, iReqHum, iRptDone,
        output oRptStart, oRptSel, oBusy, oPending, oOverrun, oTimeout
    );

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set pending bit at or after the pointer.
module rr_pick4
    import report_arbiter_pkg::*;
(
    input  logic [3:0] i_pending,
    input  logic [1:0] i_ptr,
    output logic [1:0] o_win,
    output logic       o_valid
);

    always_comb begin
        o_win   = '0;
        o_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!o_valid && i_pending[i_ptr + 2'(i)]) begin
                o_valid = 1'b1;
                o_win   = i_ptr + 2'(i);
            end
        end
    end

endmodule

// File: rtl/report_arbiter.sv
// Shares the UART report formatter among watch, SR04, temperature and humidity
// report requests: latches requests, grants round-robin, waits for done/timeout, then gaps.
module report_arbiter
    import report_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned GAP_CYC     = 100,
    parameter int unsigned CNT_W       = 20
) (
    input  logic             iClk,
    input  logic             iRst,
    report_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

    state_t           r_state;
    logic [3:0]       r_pending;
    logic [1:0]       r_ptr;
    logic [1:0]       r_pick_idx;
    logic             r_pick_vld;
    logic [CNT_W-1:0] r_cnt;
    logic             r_start;
    logic [1:0]       r_sel;
    logic             r_busy;
    logic             r_overrun;
    logic             r_timeout;

    logic [3:0]       w_req;
    logic [3:0]       w_clr;
    logic [1:0]       w_win;
    logic             w_valid;
    logic [CNT_W-1:0] w_cnt_inc;

    rr_pick4 u_pick (
        .i_pending (r_pending),
        .i_ptr     (r_ptr),
        .o_win     (w_win),
        .o_valid   (w_valid)
    );

    always_comb begin
        w_req            = '0;
        w_req[SRC_WATCH] = bus.iReqWatch;
        w_req[SRC_SR04]  = bus.iReqSr04;
        w_req[SRC_TEMP]  = bus.iReqTemp;
        w_req[SRC_HUM]   = bus.iReqHum;
        w_clr            = '0;
        if (r_state == ST_IDLE && r_pick_vld) begin
            w_clr[r_pick_idx] = 1'b1;
        end
        w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
    end

    // The pick is registered, so IDLE grants from the pending set seen one edge earlier;
    // by the time the FSM is back in IDLE the pick reflects the cleared bit.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            r_state    <= ST_IDLE;
            r_pending  <= '0;
            r_ptr      <= '0;
            r_pick_idx <= '0;
            r_pick_vld <= 1'b0;
            r_cnt      <= '0;
            r_start    <= 1'b0;
            r_sel      <= '0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_pending  <= (r_pending & ~w_clr) | w_req;
            r_overrun  <= |(w_req & r_pending & ~w_clr);
            r_pick_idx <= w_win;
            r_pick_vld <= w_valid;
            r_start    <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_pick_vld) begin
                        r_state <= ST_START;
                        r_start <= 1'b1;
                        r_sel   <= r_pick_idx;
                        r_ptr   <= r_pick_idx + 2'd1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    r_state <= ST_WAIT;
                    r_cnt   <= '0;
                end
                ST_WAIT: begin
                    if (bus.iRptDone || r_cnt == TO_LAST) begin
                        r_timeout <= !bus.iRptDone;
                        r_cnt     <= '0;
                        if (GAP_CYC == 0) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_GAP;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.oRptStart = r_start;
    assign bus.oRptSel   = r_sel;
    assign bus.oBusy     = r_busy;
    assign bus.oPending  = r_pending;
    assign bus.oOverrun  = r_overrun;
    assign bus.oTimeout  = r_timeout;

endmodule
